archer_projectile_ctl: RTL and testbench
========================================

Name: archer_projectile_ctl

Overview:
- Sequences the archer's single projectile: launch on click, per-frame flight, termination, cooldown.
- Drives position, active/animated flags, facing and direction sector into the projectile draw stage.
- Sits between mouse/archer position logic and the VGA projectile draw stage.
- Collision logic feeds a hit pulse back into this block.

Parameters:
H_RES, 1024, screen width in pixels; valid x is 0..H_RES-1
V_RES, 768, screen height in pixels; valid y is 0..V_RES-1
SPEED, 8, pixels per frame for axis-aligned flight
SPEED_DIAG, 6, pixels per frame on each axis for diagonal flight
MAX_FRAMES, 90, flight frames before forced expiry
COOLDOWN_FRAMES, 20, frames after flight ends before the next shot is accepted

Ports:
clk  in  1  system clock
rst  in  1  asynchronous active-high reset
game_active  in  2  any non-zero value = play enabled
mouse_clicked  in  1  level click; rising edge = fire request
mouse_x, mouse_y  in  12 each  aim point
archer_x, archer_y  in  12 each  launch point (archer centre)
archer_flip  in  1  archer currently facing left
frame_tick  in  1  one-cycle pulse, once per frame
hit  in  1  one-cycle pulse, projectile struck target
pos_x_proj, pos_y_proj  out  12 each  projectile centre
projectile_active  out  1  projectile exists
projectile_animated  out  1  projectile drawable
flip_hor_archer  out  1  projectile travels leftward
direction_sector  out  3  0=R 1=UR 2=U 3=UL 4=L 5=DL 6=D 7=DR
cooldown_busy  out  1  in COOLDOWN

Behaviour:
- Reset (async): state IDLE; all outputs 0; counters 0; click edge register 0.
- Fire request: mouse_clicked high this cycle, low the previous cycle.
  - Accepted only in IDLE with game_active != 0.
  - Ignored in other states; never queued.

States:
- IDLE -> AIM on accepted fire.
  - Latch archer_x/y into the position registers.
  - Latch dx = mouse_x - archer_x and dy = archer_y - mouse_y as 13-bit signed values. Up is positive dy.
- AIM (1 cycle): sector classification.
  - ax = |dx|, ay = |dy|, widths 15 bits.
  - 5*ay <= 2*ax: horizontal. dx >= 0 gives sector 0, else sector 4.
  - Else 5*ax <= 2*ay: vertical. dy > 0 gives sector 2, else sector 6.
  - Else diagonal, chosen by signs: 1, 3, 5 or 7.
  - dx = dy = 0: sector 4 if archer_flip, else sector 0.
  - Velocity: axis sectors use SPEED; diagonal sectors use SPEED_DIAG on both axes. Screen vy = -dy direction.
  - flip_hor_archer = 1 for sectors 3, 4, 5; 0 otherwise.
  - projectile_active = 1. Frame counter cleared. Go to FLIGHT.
- FLIGHT:
  - Each frame_tick: compute next position as 13-bit signed.
  - Next x < 0, x > H_RES-1, y < 0 or y > V_RES-1: go to COOLDOWN. The position is not updated.
  - Otherwise: update position and increment the frame counter.
  - projectile_animated goes 1 on the first frame_tick in FLIGHT.
  - Frame counter reaching MAX_FRAMES: go to COOLDOWN.
  - hit: go to COOLDOWN immediately. If hit and frame_tick coincide, hit wins and there is no position update.
- COOLDOWN:
  - projectile_active = 0 and projectile_animated = 0 on entry cycle+1.
  - Position holds its last value.
  - cooldown_busy = 1.
  - Count frame_ticks; after COOLDOWN_FRAMES ticks go to IDLE and clear cooldown_busy.
- game_active == 0 in any state: next cycle IDLE with all flags cleared. The cooldown is not completed.
- Latency:
  - Click edge to projectile_active: 2 cycles (IDLE->AIM, AIM->FLIGHT).
  - Outputs are registered.
- direction_sector and flip_hor_archer hold their values until the next AIM.

Optional Feature:
- Macro: ARCHER_PROJ_GRAVITY_EN.
- Defined: in FLIGHT, after each position update, vy += 1 (screen-down positive), saturating at +SPEED.
  - direction_sector is re-evaluated from the current (vx, vy) with the same 5:2 rule each frame_tick.
- Undefined: velocity is constant for the whole flight; sector is fixed at AIM.

Test Plan:
- Right shot: archer (100,300), mouse (400,300), click, 3 frame_ticks -> sector 0, flip 0; pos 108, 116, 124 at y=300; active 2 cycles after edge; animated after first tick.
- Up-left diagonal: archer (500,400), mouse (400,300) -> sector 3, flip 1; after 2 ticks pos (488,388).
- Edge exit: archer (1020,100) shooting right -> first tick leaves pos 1020, enters COOLDOWN, active=0; after 20 ticks cooldown_busy=0 and IDLE.
- Hit and frame_tick in the same cycle during FLIGHT -> no position update, COOLDOWN entered; click during COOLDOWN -> ignored, no launch after cooldown.
- Max range: archer (10,700) shooting up, no hit, no edge reached -> pos stops at y=700-8*90=-20, so exit occurs at tick 88 with y=4 held. Separately, with MAX_FRAMES=5: expiry after 5 ticks at y=660.
- game_active to 0 mid-flight -> next cycle all outputs flags 0, IDLE; a new click with game_active=1 launches immediately with no cooldown.

Source files
------------

// File: rtl/archer_projectile_ctl_if.sv
// rtl/archer_projectile_ctl_if.sv - archer projectile controller signal bundle
// master drives aim/fire/frame inputs; slave is the controller.
interface archer_projectile_ctl_if;
  logic [1:0]  i_game_active;
  logic        i_mouse_clicked;
  logic [11:0] i_mouse_x;
  logic [11:0] i_mouse_y;
  logic [11:0] i_archer_x;
  logic [11:0] i_archer_y;
  logic        i_archer_flip;
  logic        i_frame_tick;
  logic        i_hit;
  logic [11:0] o_pos_x_proj;
  logic [11:0] o_pos_y_proj;
  logic        o_projectile_active;
  logic        o_projectile_animated;
  logic        o_flip_hor_archer;
  logic [2:0]  o_direction_sector;
  logic        o_cooldown_busy;

  modport master (
    output i_game_active, i_mouse_clicked, i_mouse_x, i_mouse_y,
           i_archer_x, i_archer_y, i_archer_flip, i_frame_tick, i_hit,
    input  o_pos_x_proj, o_pos_y_proj, o_projectile_active,
           o_projectile_animated, o_flip_hor_archer, o_direction_sector,
           o_cooldown_busy
  );

  modport slave (
    input  i_game_active, i_mouse_clicked, i_mouse_x, i_mouse_y,
           i_archer_x, i_archer_y, i_archer_flip, i_frame_tick, i_hit,
    output o_pos_x_proj, o_pos_y_proj, o_projectile_active,
           o_projectile_animated, o_flip_hor_archer, o_direction_sector,
           o_cooldown_busy
  );
endinterface

// File: rtl/archer_projectile_ctl.sv
// rtl/archer_projectile_ctl.sv - single projectile launch/flight/cooldown sequencer
// Optional macro ARCHER_PROJ_GRAVITY_EN adds per-frame gravity and sector re-evaluation.
module archer_projectile_ctl #(
  parameter int H_RES           = 1024,
  parameter int V_RES           = 768,
  parameter int SPEED           = 8,
  parameter int SPEED_DIAG      = 6,
  parameter int MAX_FRAMES      = 90,
  parameter int COOLDOWN_FRAMES = 20
) (
  input  logic                    clk,
  input  logic                    rst,
  archer_projectile_ctl_if.slave  bus
);

  typedef enum logic [1:0] {S_IDLE, S_AIM, S_FLIGHT, S_COOLDOWN} state_t;

  localparam logic signed [12:0] X_MAX = 13'(H_RES - 1);
  localparam logic signed [12:0] Y_MAX = 13'(V_RES - 1);
  localparam logic signed [12:0] V_S   = 13'(SPEED);
  localparam logic signed [12:0] V_D   = 13'(SPEED_DIAG);

  state_t             r_state, w_next;
  logic               r_click_d;
  logic signed [12:0] r_dx, r_dy, r_vx, r_vy;
  logic [11:0]        r_px, r_py;
  logic [15:0]        r_fcnt, r_ccnt;
  logic               r_active, r_animated, r_flip, r_busy;
  logic [2:0]         r_sector;

  logic               w_play, w_fire, w_out, w_move;
  logic signed [12:0] w_nx, w_ny, w_vx, w_vy;
  logic [2:0]         w_sec;

  // 5:2 slope rule; dy is positive upward
  function automatic logic [2:0] classify(input logic signed [12:0] dx,
                                          input logic signed [12:0] dy,
                                          input logic flip);
    logic signed [14:0] sx, sy;
    logic [14:0]        ax, ay;
    logic [17:0]        ax5, ay5, ax2, ay2;
    sx  = {{2{dx[12]}}, dx};
    sy  = {{2{dy[12]}}, dy};
    ax  = sx[14] ? 15'(-sx) : 15'(sx);
    ay  = sy[14] ? 15'(-sy) : 15'(sy);
    ax5 = 18'(ax) * 18'd5;
    ay5 = 18'(ay) * 18'd5;
    ax2 = {2'b00, ax, 1'b0};
    ay2 = {2'b00, ay, 1'b0};
    if (dx == 13'sd0 && dy == 13'sd0) return flip ? 3'd4 : 3'd0;
    if (ay5 <= ax2) return dx[12] ? 3'd4 : 3'd0;
    if (ax5 <= ay2) return (dy > 13'sd0) ? 3'd2 : 3'd6;
    if (!dx[12]) return (dy > 13'sd0) ? 3'd1 : 3'd7;
    return (dy > 13'sd0) ? 3'd3 : 3'd5;
  endfunction

  assign w_play = |bus.i_game_active;
  assign w_fire = w_play && (r_state == S_IDLE) && bus.i_mouse_clicked && !r_click_d;
  assign w_nx   = $signed({1'b0, r_px}) + r_vx;
  assign w_ny   = $signed({1'b0, r_py}) + r_vy;
  assign w_out  = (w_nx < 13'sd0) || (w_nx > X_MAX) || (w_ny < 13'sd0) || (w_ny > Y_MAX);
  assign w_move = w_play && (r_state == S_FLIGHT) && bus.i_frame_tick && !bus.i_hit && !w_out;
  assign w_sec  = classify(r_dx, r_dy, bus.i_archer_flip);

`ifdef ARCHER_PROJ_GRAVITY_EN
  logic signed [12:0] w_vy_g;
  assign w_vy_g = (r_vy >= V_S) ? r_vy : r_vy + 13'sd1;
`endif

  // screen y grows downward, so upward sectors get negative vy
  always_comb begin
    w_vx = 13'sd0;
    w_vy = 13'sd0;
    case (w_sec)
      3'd0: w_vx = V_S;
      3'd1: begin w_vx = V_D;  w_vy = -V_D; end
      3'd2: w_vy = -V_S;
      3'd3: begin w_vx = -V_D; w_vy = -V_D; end
      3'd4: w_vx = -V_S;
      3'd5: begin w_vx = -V_D; w_vy = V_D;  end
      3'd6: w_vy = V_S;
      default: begin w_vx = V_D; w_vy = V_D; end
    endcase
  end

  always_comb begin
    w_next = r_state;
    if (!w_play) begin
      w_next = S_IDLE;
    end else begin
      case (r_state)
        S_IDLE:   if (w_fire) w_next = S_AIM;
        S_AIM:    w_next = S_FLIGHT;
        S_FLIGHT: begin
          if (bus.i_hit) w_next = S_COOLDOWN;
          else if (bus.i_frame_tick &&
                   (w_out || (r_fcnt + 16'd1 >= 16'(MAX_FRAMES)))) w_next = S_COOLDOWN;
        end
        default:  if (bus.i_frame_tick && r_ccnt == 16'(COOLDOWN_FRAMES - 1)) w_next = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_next;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_click_d <= 1'b0;
      r_dx <= '0; r_dy <= '0; r_vx <= '0; r_vy <= '0;
      r_px <= '0; r_py <= '0; r_fcnt <= '0; r_ccnt <= '0;
      r_active <= 1'b0; r_animated <= 1'b0; r_flip <= 1'b0; r_busy <= 1'b0;
      r_sector <= '0;
    end else begin
      r_click_d <= bus.i_mouse_clicked;
      if (!w_play) begin
        r_active   <= 1'b0;
        r_animated <= 1'b0;
        r_busy     <= 1'b0;
      end else begin
        if (w_fire) begin
          r_px <= bus.i_archer_x;
          r_py <= bus.i_archer_y;
          r_dx <= $signed({1'b0, bus.i_mouse_x}) - $signed({1'b0, bus.i_archer_x});
          r_dy <= $signed({1'b0, bus.i_archer_y}) - $signed({1'b0, bus.i_mouse_y});
        end
        if (r_state == S_AIM) begin
          r_sector <= w_sec;
          r_flip   <= (w_sec == 3'd3) || (w_sec == 3'd4) || (w_sec == 3'd5);
          r_vx     <= w_vx;
          r_vy     <= w_vy;
          r_active <= 1'b1;
          r_fcnt   <= '0;
        end
        if (w_move) begin
          r_px       <= w_nx[11:0];
          r_py       <= w_ny[11:0];
          r_fcnt     <= r_fcnt + 16'd1;
          r_animated <= 1'b1;
`ifdef ARCHER_PROJ_GRAVITY_EN
          r_vy       <= w_vy_g;
          r_sector   <= classify(r_vx, -w_vy_g, r_flip);
`endif
        end
        // later assignment overrides the move flags when the last frame expires
        if (r_state == S_FLIGHT && w_next == S_COOLDOWN) begin
          r_active   <= 1'b0;
          r_animated <= 1'b0;
          r_busy     <= 1'b1;
          r_ccnt     <= '0;
        end
        if (r_state == S_COOLDOWN && bus.i_frame_tick) begin
          if (w_next == S_IDLE) r_busy <= 1'b0;
          else                  r_ccnt <= r_ccnt + 16'd1;
        end
      end
    end
  end

  assign bus.o_pos_x_proj          = r_px;
  assign bus.o_pos_y_proj          = r_py;
  assign bus.o_projectile_active   = r_active;
  assign bus.o_projectile_animated = r_animated;
  assign bus.o_flip_hor_archer     = r_flip;
  assign bus.o_direction_sector    = r_sector;
  assign bus.o_cooldown_busy       = r_busy;

endmodule

// File: tb/tb_archer_projectile_ctl.sv
// tb/tb_archer_projectile_ctl.sv - directed and random checks against a closed-form flight model
module tb_archer_projectile_ctl;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  archer_projectile_ctl_if ifa ();
  archer_projectile_ctl_if ifb ();

  archer_projectile_ctl dut (.clk(clk), .rst(rst), .bus(ifa));
  archer_projectile_ctl #(.MAX_FRAMES(5)) dut5 (.clk(clk), .rst(rst), .bus(ifb));

  assign ifb.i_game_active   = ifa.i_game_active;
  assign ifb.i_mouse_clicked = ifa.i_mouse_clicked;
  assign ifb.i_mouse_x       = ifa.i_mouse_x;
  assign ifb.i_mouse_y       = ifa.i_mouse_y;
  assign ifb.i_archer_x      = ifa.i_archer_x;
  assign ifb.i_archer_y      = ifa.i_archer_y;
  assign ifb.i_archer_flip   = ifa.i_archer_flip;
  assign ifb.i_frame_tick    = ifa.i_frame_tick;
  assign ifb.i_hit           = ifa.i_hit;

  int total = 0;
  int bad   = 0;

  int vx_tab [8] = '{8, 6, 0, -6, -8, -6, 0, 6};
  int vy_tab [8] = '{0, -6, -8, -6, 0, 6, 8, 6};

  int m_x0, m_y0, m_vx, m_vy, m_k, m_cd, m_sec;
  bit m_flip, m_live, m_done;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic int sector_of(int dx, int dy, bit flip);
    int ax, ay;
    ax = (dx < 0) ? -dx : dx;
    ay = (dy < 0) ? -dy : dy;
    if (dx == 0 && dy == 0) return flip ? 4 : 0;
    if (5 * ay <= 2 * ax) return (dx >= 0) ? 0 : 4;
    if (5 * ax <= 2 * ay) return (dy > 0) ? 2 : 6;
    if (dx > 0) return (dy > 0) ? 1 : 7;
    return (dy > 0) ? 3 : 5;
  endfunction

  task automatic check_outputs(input string tag);
    check({tag, ".x"},      {20'd0, ifa.o_pos_x_proj}, m_x0 + m_k * m_vx);
    check({tag, ".y"},      {20'd0, ifa.o_pos_y_proj}, m_y0 + m_k * m_vy);
    check({tag, ".active"}, {31'd0, ifa.o_projectile_active}, (m_live && !m_done) ? 1 : 0);
    check({tag, ".anim"},   {31'd0, ifa.o_projectile_animated}, (m_live && !m_done && m_k > 0) ? 1 : 0);
    check({tag, ".busy"},   {31'd0, ifa.o_cooldown_busy}, (m_live && m_done && m_cd < 20) ? 1 : 0);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    step();
    rst = 1'b0;
    m_x0 = 0; m_y0 = 0; m_vx = 0; m_vy = 0; m_k = 0; m_cd = 0; m_sec = 0;
    m_flip = 0; m_live = 0; m_done = 0;
    step();
  endtask

  task automatic launch(input int ax, input int ay, input int mx, input int my, input bit flip,
                        input string tag);
    ifa.i_archer_x = 12'(ax); ifa.i_archer_y = 12'(ay);
    ifa.i_mouse_x  = 12'(mx); ifa.i_mouse_y  = 12'(my);
    ifa.i_archer_flip = flip;
    ifa.i_mouse_clicked = 1'b1;
    step();
    check({tag, ".lat1"}, {31'd0, ifa.o_projectile_active}, 0);
    m_sec  = sector_of(mx - ax, ay - my, flip);
    m_vx   = vx_tab[m_sec];
    m_vy   = vy_tab[m_sec];
    m_flip = (m_sec >= 3 && m_sec <= 5);
    m_x0 = ax; m_y0 = ay; m_k = 0; m_cd = 0; m_live = 1; m_done = 0;
    step();
    ifa.i_mouse_clicked = 1'b0;
    check({tag, ".sector"}, {29'd0, ifa.o_direction_sector}, m_sec);
    check({tag, ".flip"},   {31'd0, ifa.o_flip_hor_archer}, m_flip ? 1 : 0);
    check_outputs({tag, ".launch"});
  endtask

  task automatic do_tick(input bit t, input bit h, input string tag);
    int nx, ny;
    ifa.i_frame_tick = t;
    ifa.i_hit = h;
    step();
    ifa.i_frame_tick = 1'b0;
    ifa.i_hit = 1'b0;
    if (m_live && !m_done) begin
      if (h) m_done = 1;
      else if (t) begin
        nx = m_x0 + (m_k + 1) * m_vx;
        ny = m_y0 + (m_k + 1) * m_vy;
        if (nx < 0 || nx > 1023 || ny < 0 || ny > 767) m_done = 1;
        else begin
          m_k++;
          if (m_k == 90) m_done = 1;
        end
      end
    end else if (m_live && m_done && t && m_cd < 20) begin
      m_cd++;
    end
    check_outputs(tag);
  endtask

  task automatic abort(input string tag);
    ifa.i_game_active = 2'd0;
    step();
    m_live = 0;
    check_outputs({tag, ".abort"});
    check({tag, ".abort.sector"}, {29'd0, ifa.o_direction_sector}, m_sec);
    ifa.i_game_active = 2'($urandom_range(1, 3));
    step();
  endtask

  initial begin
    int ax, ay, mx, my, n;
    ifa.i_game_active = 2'd1;
    ifa.i_mouse_clicked = 1'b0;
    ifa.i_mouse_x = '0; ifa.i_mouse_y = '0;
    ifa.i_archer_x = '0; ifa.i_archer_y = '0;
    ifa.i_archer_flip = 1'b0;
    ifa.i_frame_tick = 1'b0;
    ifa.i_hit = 1'b0;

    do_reset();
    check_outputs("reset");
    check("reset.sector", {29'd0, ifa.o_direction_sector}, 0);
    check("reset.flip",   {31'd0, ifa.o_flip_hor_archer}, 0);

    launch(100, 300, 400, 300, 0, "right");
    for (int i = 0; i < 3; i++) do_tick(1, 0, "right.tick");
    check("right.x3", {20'd0, ifa.o_pos_x_proj}, 124);
    abort("right");

    launch(500, 400, 400, 300, 0, "upleft");
    do_tick(1, 0, "upleft.tick");
    do_tick(1, 0, "upleft.tick");
    check("upleft.x2", {20'd0, ifa.o_pos_x_proj}, 488);
    check("upleft.y2", {20'd0, ifa.o_pos_y_proj}, 388);
    abort("upleft");

    launch(1020, 100, 2000, 100, 0, "edge");
    do_tick(1, 0, "edge.exit");
    for (int i = 0; i < 20; i++) do_tick(1, 0, "edge.cool");
    check("edge.busy_end", {31'd0, ifa.o_cooldown_busy}, 0);

    launch(200, 200, 600, 200, 0, "hit");
    do_tick(1, 0, "hit.tick");
    do_tick(1, 1, "hit.coincide");
    ifa.i_mouse_clicked = 1'b1;
    step();
    ifa.i_mouse_clicked = 1'b0;
    check_outputs("hit.click_ignored");
    for (int i = 0; i < 20; i++) do_tick(1, 0, "hit.cool");
    for (int i = 0; i < 3; i++) begin
      step();
      check_outputs("hit.no_queue");
    end

    launch(300, 300, 300, 100, 0, "gameoff");
    do_tick(1, 0, "gameoff.tick");
    do_tick(1, 0, "gameoff.tick");
    abort("gameoff");
    launch(300, 300, 500, 500, 1, "relaunch");
    do_tick(1, 0, "relaunch.tick");
    abort("relaunch");

    for (int i = 0; i < 10; i++) begin
      ax = $urandom_range(0, 1023);
      ay = $urandom_range(0, 767);
      mx = (i == 0) ? ax : $urandom_range(0, 1023);
      my = (i == 0) ? ay : $urandom_range(0, 767);
      launch(ax, ay, mx, my, (i == 0) ? 1'b1 : 1'($urandom_range(0, 1)), "rand");
      n = $urandom_range(1, 12);
      for (int k = 0; k < n; k++)
        do_tick(1'($urandom_range(0, 1)), ($urandom_range(0, 7) == 0), "rand.tick");
      abort("rand");
    end

    do_reset();
    launch(10, 700, 10, 0, 0, "range");
    for (int k = 1; k <= 88; k++) begin
      do_tick(1, 0, "range.tick");
      if (k == 4) begin
        check("range5.y4",      {20'd0, ifb.o_pos_y_proj}, 668);
        check("range5.active4", {31'd0, ifb.o_projectile_active}, 1);
      end
      if (k == 5) begin
        check("range5.y5",      {20'd0, ifb.o_pos_y_proj}, 660);
        check("range5.active5", {31'd0, ifb.o_projectile_active}, 0);
        check("range5.busy5",   {31'd0, ifb.o_cooldown_busy}, 1);
      end
    end
    check("range.y_held", {20'd0, ifa.o_pos_y_proj}, 4);
    check("range.active", {31'd0, ifa.o_projectile_active}, 0);
    for (int i = 0; i < 20; i++) do_tick(1, 0, "range.cool");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
